multiword_adder_sequencer: RTL and testbench

//   Sequences one shared N-bit carry-lookahead adder slice over WORDS words to add
//   two W = N*WORDS bit operands, least significant word first, one word per cycle.
//   The carry is chained through a register between words.

---
 rtl/multiword_adder_sequencer_if.sv | 41 ++++
 rtl/multiword_adder_sequencer.sv | 166 ++++++++++++++++
 tb/tb_multiword_adder_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiword_adder_sequencer_if.sv
// rtl/multiword_adder_sequencer_if.sv - operand/result handshake bundle for the word-serial adder (option: MWADD_SUB_EN)
interface multiword_adder_sequencer_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
`ifdef MWADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic         busy;

`ifdef MWADD_SUB_EN
  modport master (
    output in_valid, a_in, b_in, sub, out_ready,
    input  in_ready, out_valid, sum_out, carry_out, busy
  );
  modport slave (
    input  in_valid, a_in, b_in, sub, out_ready,
    output in_ready, out_valid, sum_out, carry_out, busy
  );
`else
  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, sum_out, carry_out, busy
  );
  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, sum_out, carry_out, busy
  );
`endif

endinterface

// File: rtl/multiword_adder_sequencer.sv
// rtl/multiword_adder_sequencer.sv - wide add sequenced one word per cycle over a shared CLA slice (option: MWADD_SUB_EN)

// Carry-lookahead adder, carry-in is supplied by the caller through bit 0 of both operands
module mwadd_cla #(
  parameter int M = 5
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] s,
  output logic         co
);
  logic [M-1:0] g;
  logic [M-1:0] p;
  logic [M:0]   c;
  logic         term;

  // Each carry is a flat OR of generate terms gated by the propagates above them
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    s  = p ^ c[M-1:0];
    co = c[M];
  end
endmodule

module multiword_adder_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  multiword_adder_sequencer_if.slave  bus
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_out_q, carry_out_d;
`ifdef MWADD_SUB_EN
  logic          sub_q, sub_d;
`endif

  logic [N-1:0]  b_w;
  logic [N-1:0]  slice_sum;
  logic          slice_co;
  logic          unused_lsb;

  // Current word of B, inverted for subtraction
  always_comb begin
`ifdef MWADD_SUB_EN
    b_w = sub_q ? ~b_sh_q[N-1:0] : b_sh_q[N-1:0];
`else
    b_w = b_sh_q[N-1:0];
`endif
  end

  // Carry enters as bit 0 of both operands so the N+1 bit slice adds it in; bit 0 of the result is dropped
  mwadd_cla #(.M(N + 1)) u_cla (
    .a  ({a_sh_q[N-1:0], carry_q}),
    .b  ({b_w, carry_q}),
    .s  ({slice_sum, unused_lsb}),
    .co (slice_co)
  );

  // Next-state and datapath control for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
`ifdef MWADD_SUB_EN
    sub_d       = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a_in;
          b_sh_d  = bus.b_in;
          idx_d   = '0;
`ifdef MWADD_SUB_EN
          sub_d   = bus.sub;
          carry_d = bus.sub;
`else
          carry_d = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*N +: N] = slice_sum;
        carry_d             = slice_co;
        a_sh_d              = a_sh_q >> N;
        b_sh_d              = b_sh_q >> N;
        if (idx_q == LAST_IDX) begin
          carry_out_d = slice_co;
          idx_d       = '0;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
`ifdef MWADD_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
`ifdef MWADD_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum_out   = sum_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// tb/tb_multiword_adder_sequencer.sv - scoreboard bench for the word-serial adder (option: MWADD_SUB_EN)
module tb_multiword_adder_sequencer;
  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multiword_adder_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

  multiword_adder_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int asserts = 0;
  int fails   = 0;
  logic [W:0] exp_q[$];

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] bb;
    bb = s ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
  endfunction

  task automatic set_sub(input logic s);
`ifdef MWADD_SUB_EN
    bus.sub = s;
`else
    if (s) $display("note: sub requested in add-only build");
`endif
  endtask

  // Presents operands until accepted; returns at the negedge after the accepting edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [W:0] expv, output bit ok);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    set_sub(s);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ok = bus.in_ready;
    if (ok) exp_q.push_back(expv);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    asserts++; if (bus.in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    asserts++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    asserts++; if (bus.busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    asserts++; if (bus.sum_out !== '0)     begin fails++; $display("FAIL reset_sum got %h want 0000", bus.sum_out); end
    asserts++; if (bus.carry_out !== 1'b0) begin fails++; $display("FAIL reset_carry got %b want 0", bus.carry_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    logic [W-1:0] ta[4] = '{16'h1234, 16'hFFFF, 16'h8421, 16'hABCD};
    logic [W-1:0] tb[4] = '{16'h4321, 16'h0001, 16'h7BDF, 16'h1111};
    logic [W:0]   te[4] = '{17'h0_5555, 17'h1_0000, 17'h1_0000, 17'h0_BCDE};
    bit ok;
    int lat;
    logic [W:0] e;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], 1'b0, te[i], ok);
      asserts++; if (!ok) begin fails++; $display("FAIL add_accept[%0d] got no accept want accept", i); end
      asserts++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        fails++; $display("FAIL add_run_flags[%0d] got ready=%b busy=%b want 0/1", i, bus.in_ready, bus.busy);
      end
      wait_out(lat);
      asserts++; if (lat !== WORDS) begin fails++; $display("FAIL add_latency[%0d] got %0d want %0d", i, lat, WORDS); end
      if (exp_q.size() == 0) begin
        asserts++; fails++; $display("FAIL add_scoreboard[%0d] got empty want entry", i);
      end else begin
        e = exp_q.pop_front();
        asserts++; if (bus.sum_out !== e[W-1:0]) begin fails++; $display("FAIL add_sum[%0d] got %h want %h", i, bus.sum_out, e[W-1:0]); end
        asserts++; if (bus.carry_out !== e[W]) begin fails++; $display("FAIL add_carry[%0d] got %b want %b", i, bus.carry_out, e[W]); end
      end
      handshake();
      asserts++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL add_release[%0d] got valid=%b ready=%b want 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    int lat;
    logic [W:0] e;
    send(16'h00FF, 16'h0001, 1'b0, 17'h0_0100, ok);
    wait_out(lat);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    asserts++; if (!ok || lat !== WORDS) begin fails++; $display("FAIL stall_setup got ok=%b lat=%0d want 1/%0d", ok, lat, WORDS); end
    bus.in_valid = 1'b1;
    bus.a_in     = 16'hAAAA;
    bus.b_in     = 16'h5555;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      asserts++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        fails++; $display("FAIL stall_flags[%0d] got valid=%b ready=%b want 1/0", c, bus.out_valid, bus.in_ready);
      end
      asserts++; if ({bus.carry_out, bus.sum_out} !== e) begin
        fails++; $display("FAIL stall_hold[%0d] got %h want %h", c, {bus.carry_out, bus.sum_out}, e);
      end
    end
    handshake();
    asserts++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL stall_only_output got busy=%b ready=%b valid=%b want 0/1/0", bus.busy, bus.in_ready, bus.out_valid);
    end
    asserts++; if (bus.sum_out !== 16'h0100) begin fails++; $display("FAIL stall_sum_kept got %h want 0100", bus.sum_out); end
    exp_q.push_back(17'h0_FFFF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    asserts++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL stall_late_accept got busy=%b want 1", bus.busy); end
    wait_out(lat);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    asserts++; if (lat !== WORDS || {bus.carry_out, bus.sum_out} !== e) begin
      fails++; $display("FAIL stall_next_op got lat=%0d res=%h want %0d/%h", lat, {bus.carry_out, bus.sum_out}, WORDS, e);
    end
    handshake();
  endtask

  task automatic test_reset_mid;
    bit ok;
    int lat;
    logic [W:0] e;
    send(16'h1234, 16'h4321, 1'b0, 17'h0_5555, ok);
    exp_q.delete();
    repeat (2) @(negedge clk);
    asserts++; if (bus.sum_out[7:0] !== 8'h55) begin fails++; $display("FAIL midrst_partial got %h want 55", bus.sum_out[7:0]); end
    #1 reset = 1'b1;
    #1;
    asserts++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum_out !== '0) begin
      fails++; $display("FAIL midrst_clear got valid=%b busy=%b sum=%h want 0/0/0000", bus.out_valid, bus.busy, bus.sum_out);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    asserts++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %b want 1", bus.in_ready); end
    send(16'h0003, 16'h0004, 1'b0, 17'h0_0007, ok);
    wait_out(lat);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    asserts++; if (!ok || lat !== WORDS || {bus.carry_out, bus.sum_out} !== e) begin
      fails++; $display("FAIL midrst_next got ok=%b lat=%0d res=%h want 1/%0d/%h", ok, lat, {bus.carry_out, bus.sum_out}, WORDS, e);
    end
    handshake();
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av[5];
    logic [W-1:0] bv[5];
    logic [W:0] e;
    int sent, got, last_acc, cyc;
    bit load;
    for (int i = 0; i < 5; i++) begin
      av[i] = W'($urandom);
      bv[i] = W'($urandom);
    end
    sent = 0; got = 0; last_acc = -1; cyc = 0; load = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a_in      = av[0];
    bus.b_in      = bv[0];
    set_sub(1'b0);
    while (got < 5 && cyc < 200) begin
      if (bus.out_valid) begin
        asserts++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL b2b_scoreboard got unexpected output want none");
        end else begin
          e = exp_q.pop_front();
          if ({bus.carry_out, bus.sum_out} !== e) begin
            fails++; $display("FAIL b2b_result[%0d] got %h want %h", got, {bus.carry_out, bus.sum_out}, e);
          end
        end
        got++;
      end
      if (bus.in_ready && bus.in_valid) begin
        exp_q.push_back(model(av[sent], bv[sent], 1'b0));
        if (last_acc >= 0) begin
          asserts++; if (cyc - last_acc !== WORDS + 2) begin
            fails++; $display("FAIL b2b_spacing got %0d want %0d", cyc - last_acc, WORDS + 2);
          end
        end
        last_acc = cyc;
        sent++;
        load = 1;
      end
      @(negedge clk);
      cyc++;
      if (load) begin
        load = 0;
        if (sent < 5) begin
          bus.a_in = av[sent];
          bus.b_in = bv[sent];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    asserts++; if (got !== 5) begin fails++; $display("FAIL b2b_count got %0d want 5", got); end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
  endtask

`ifdef MWADD_SUB_EN
  task automatic test_sub;
    logic [W-1:0] ta[2] = '{16'h0005, 16'h0007};
    logic [W-1:0] tb[2] = '{16'h0007, 16'h0005};
    logic [W:0]   te[2] = '{17'h0_FFFE, 17'h1_0002};
    bit ok;
    int lat;
    logic [W:0] e;
    for (int i = 0; i < 2; i++) begin
      send(ta[i], tb[i], 1'b1, te[i], ok);
      wait_out(lat);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      asserts++; if (!ok || lat !== WORDS || {bus.carry_out, bus.sum_out} !== e) begin
        fails++; $display("FAIL sub[%0d] got ok=%b lat=%0d res=%h want 1/%0d/%h", i, ok, lat, {bus.carry_out, bus.sum_out}, WORDS, e);
      end
      handshake();
    end
    set_sub(1'b0);
  endtask
`endif

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    set_sub(1'b0);
    test_reset();
    test_add();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef MWADD_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
